wb_sdspi_slave: RTL
===================

Name: wb_sdspi_slave

Overview:
- Wishbone B4 classic slave that exposes the SD-over-SPI register window to bus masters such as the boot loader.
- Decodes the block-address, request-data, sclk-speed and status registers.
- On each request-data write it pulls one byte from the SD block-read core's byte stream and returns it in the ack.
- Sits between the Wishbone interconnect and the SPI SD block-read core; opens 512-byte block reads on demand.

Parameters:
- WB_DATA, 32, Wishbone data/address width.
- BASE_ADDR, 32'h92000000, register window base; the window is 16 addresses.
- SCLK_RESET, 5'h1F, reset value of sclk_speed_o (slowest divider).
- TIMEOUT_CYCLES, 1000000, maximum wb_clk cycles to wait for one SD byte.

Ports:
- wb_clk  in  1  bus clock; all logic on its rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- wb_adr_i  in  WB_DATA  byte address.
- wb_dat_i  in  WB_DATA  write data.
- wb_sel_i  in  WB_DATA/8  byte lanes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type; ignored (classic only).
- wb_bte_i  in  2  burst type; ignored.
- wb_dat_o  out  WB_DATA  read/response data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  tied 0.
- sclk_speed_o  out  5  SPI clock divider to the SD core.
- sd_start_o  out  1  one-cycle pulse that starts a block read.
- sd_block_o  out  32  block number for sd_start_o; held stable while a block is open.
- sd_byte_i  in  8  streamed byte.
- sd_byte_valid_i  in  1  byte available.
- sd_byte_ready_o  out  1  byte consumed; handshake completes when valid and ready are both 1.
- sd_err_i  in  1  SD core error, level.

Behaviour:
- Reset values (wb_rst=1 at an edge):
  - State IDLE.
  - All outputs 0 except sclk_speed_o=SCLK_RESET.
  - cur_block=0, byte_idx=0, block_open=0, last_byte=0, sticky flags=0.
  - Reset mid-transfer abandons the transfer silently; no ack is issued.
- Hit: wb_cyc_i & wb_stb_i & (wb_adr_i[WB_DATA-1:4]==BASE_ADDR[WB_DATA-1:4]); offset=wb_adr_i[3:0].
- Registers:
  - 0 BLOCK: R/W cur_block.
  - 1 RQ_DATA: write triggers a byte fetch; read returns {24'b0,last_byte} with no fetch.
  - 2 SCLK: R/W, bits [4:0]; the write takes effect only when wb_sel_i[0]=1.
  - 3 STATUS: read {21'b0, byte_idx[8:0], timeout_sticky, sd_err_sticky}; any write clears both sticky bits.
  - Other offsets: wb_err_o pulse, no side effects.
- States: IDLE, OPEN_BLOCK, WAIT_BYTE, ACK, ERR, WAIT_STB_LOW.
- IDLE on hit:
  - Register reads, BLOCK/SCLK/STATUS writes and unmapped offsets respond the next cycle: ACK (or ERR for unmapped).
  - RQ_DATA write with block_open=0 goes to OPEN_BLOCK.
  - RQ_DATA write with block_open=1 goes to WAIT_BYTE.
- BLOCK write: cur_block<=wb_dat_i, byte_idx<=0, block_open<=0; the next fetch reopens the block.
- OPEN_BLOCK: sd_start_o=1 for exactly one cycle with sd_block_o=cur_block; block_open<=1; go to WAIT_BYTE.
- WAIT_BYTE: timeout counter runs from 0.
  - sd_byte_valid_i=1: sd_byte_ready_o=1 that same cycle, last_byte<=sd_byte_i, go to ACK.
  - Byte accounting on that handshake: byte_idx==511 wraps to 0, block_open<=0 and cur_block<=cur_block+1 (32-bit wrap); otherwise byte_idx+1.
  - sd_err_i=1 (has priority over valid in the same cycle): sd_err_sticky<=1, block_open<=0, go to ERR.
  - Counter reaches TIMEOUT_CYCLES-1: timeout_sticky<=1, block_open<=0, go to ERR.
- ACK / ERR:
  - Exactly one-cycle wb_ack_o / wb_err_o.
  - wb_dat_o is valid in the ACK cycle: register value, or {24'b0,last_byte} for RQ_DATA writes.
  - wb_dat_o=0 in ERR and in all other cycles.
- WAIT_STB_LOW: entered after ACK/ERR; returns to IDLE when wb_stb_i=0. This guarantees one termination per strobe even if a master holds stb.
- Master drops wb_cyc_i while in OPEN_BLOCK or WAIT_BYTE: the fetch completes internally, no termination is issued, and the FSM returns to IDLE.
- Latency:
  - Register access: 2 cycles from strobe to ack.
  - RQ_DATA on an open block: strobe, WAIT_BYTE, then ack, i.e. 2 cycles plus the SD byte wait.
  - RQ_DATA on a closed block adds one cycle for OPEN_BLOCK.

Test Plan:
- Reset, then read offset 2 -> ack on the second cycle with dat=0x1F. Write 0x05 with sel=4'b0001, read back -> 0x05, sclk_speed_o=5.
- Write BLOCK=0x100, then RQ_DATA=1, with the SD model returning 0xA5 after 10 cycles -> one sd_start_o pulse with sd_block_o=0x100, ack with dat=0x000000A5, STATUS byte_idx=1.
- Stream 512 RQ_DATA fetches -> exactly one sd_start_o pulse. The 513th fetch -> second pulse with sd_block_o=0x101, and byte_idx=1 after that fetch.
- SD model never asserts valid, TIMEOUT_CYCLES=64 -> wb_err_o pulse about 65 cycles after the strobe, STATUS=0x2. A write to STATUS clears it -> 0x0.
- Access offset 5, and separately hold stb high after an ack -> single err/ack pulse each, with no second termination until stb drops.
- Assert wb_rst while in WAIT_BYTE -> no ack, all outputs 0, sclk_speed_o=0x1F, byte_idx=0 on the next STATUS read.

Source files
------------

// File: rtl/wb_sdspi_slave.sv
// Wishbone B4 classic register window in front of the SD-over-SPI block-read core.
// Each RQ_DATA write pulls one streamed SD byte and opens 512-byte block reads on demand.
module wb_sdspi_slave #(
  parameter int                 WB_DATA        = 32,
  parameter logic [WB_DATA-1:0] BASE_ADDR      = 32'h9200_0000,
  parameter logic [4:0]         SCLK_RESET     = 5'h1F,
  parameter int                 TIMEOUT_CYCLES = 1000000
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic [WB_DATA-1:0]   wb_adr_i,
  input  logic [WB_DATA-1:0]   wb_dat_i,
  input  logic [WB_DATA/8-1:0] wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic [WB_DATA-1:0]   wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic [4:0]           sclk_speed_o,
  output logic                 sd_start_o,
  output logic [31:0]          sd_block_o,
  input  logic [7:0]           sd_byte_i,
  input  logic                 sd_byte_valid_i,
  output logic                 sd_byte_ready_o,
  input  logic                 sd_err_i
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_OPEN_BLOCK   = 3'd1,
    S_WAIT_BYTE    = 3'd2,
    S_ACK          = 3'd3,
    S_ERR          = 3'd4,
    S_WAIT_STB_LOW = 3'd5
  } state_e;

  state_e             state_r, state_next_s;
  logic [31:0]        cur_block_r, cur_block_next_s;
  logic [8:0]         byte_idx_r, byte_idx_next_s;
  logic               block_open_r, block_open_next_s;
  logic [7:0]         last_byte_r, last_byte_next_s;
  logic [4:0]         sclk_r, sclk_next_s;
  logic               tmo_sticky_r, tmo_sticky_next_s;
  logic               err_sticky_r, err_sticky_next_s;
  logic [TMO_W-1:0]   tmo_cnt_r, tmo_cnt_next_s;
  logic [31:0]        sd_block_r, sd_block_next_s;
  logic [WB_DATA-1:0] dat_next_s;
  logic [WB_DATA-1:0] rd_data_s;
  logic [3:0]         offset_s;
  logic               hit_s;
  logic               unused_s;

  assign offset_s        = wb_adr_i[3:0];
  assign hit_s           = wb_cyc_i & wb_stb_i & (wb_adr_i[WB_DATA-1:4] == BASE_ADDR[WB_DATA-1:4]);
  assign wb_rty_o        = 1'b0;
  assign sclk_speed_o    = sclk_r;
  assign sd_block_o      = sd_block_r;
  // sd_err_i wins over a same-cycle byte, so the byte is not consumed then
  assign sd_byte_ready_o = (state_r == S_WAIT_BYTE) & sd_byte_valid_i & ~sd_err_i;
  assign unused_s        = ^{wb_cti_i, wb_bte_i, wb_sel_i};

  // Register read multiplexer
  always_comb begin
    rd_data_s = {WB_DATA{1'b0}};
    case (offset_s)
      4'd0:    rd_data_s = WB_DATA'(cur_block_r);
      4'd1:    rd_data_s = WB_DATA'(last_byte_r);
      4'd2:    rd_data_s = WB_DATA'(sclk_r);
      4'd3:    rd_data_s = WB_DATA'({byte_idx_r, tmo_sticky_r, err_sticky_r});
      default: rd_data_s = {WB_DATA{1'b0}};
    endcase
  end

  // Next-state and register-update logic
  always_comb begin
    state_next_s      = state_r;
    cur_block_next_s  = cur_block_r;
    byte_idx_next_s   = byte_idx_r;
    block_open_next_s = block_open_r;
    last_byte_next_s  = last_byte_r;
    sclk_next_s       = sclk_r;
    tmo_sticky_next_s = tmo_sticky_r;
    err_sticky_next_s = err_sticky_r;
    tmo_cnt_next_s    = tmo_cnt_r;
    sd_block_next_s   = sd_block_r;
    dat_next_s        = rd_data_s;
    case (state_r)
      S_IDLE: begin
        if (hit_s) begin
          tmo_cnt_next_s = {TMO_W{1'b0}};
          case (offset_s)
            4'd0: begin
              state_next_s      = S_ACK;
              cur_block_next_s  = wb_we_i ? 32'(wb_dat_i) : cur_block_r;
              byte_idx_next_s   = wb_we_i ? 9'd0 : byte_idx_r;
              block_open_next_s = wb_we_i ? 1'b0 : block_open_r;
            end
            4'd1: begin
              if (wb_we_i) begin
                state_next_s    = block_open_r ? S_WAIT_BYTE : S_OPEN_BLOCK;
                sd_block_next_s = block_open_r ? sd_block_r : cur_block_r;
              end else begin
                state_next_s = S_ACK;
              end
            end
            4'd2: begin
              state_next_s = S_ACK;
              sclk_next_s  = (wb_we_i & wb_sel_i[0]) ? wb_dat_i[4:0] : sclk_r;
            end
            4'd3: begin
              state_next_s      = S_ACK;
              tmo_sticky_next_s = wb_we_i ? 1'b0 : tmo_sticky_r;
              err_sticky_next_s = wb_we_i ? 1'b0 : err_sticky_r;
            end
            default: state_next_s = S_ERR;
          endcase
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_OPEN_BLOCK: begin
        block_open_next_s = 1'b1;
        state_next_s      = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        // A master that dropped cyc gets no termination; the fetch still lands
        if (sd_err_i) begin
          err_sticky_next_s = 1'b1;
          block_open_next_s = 1'b0;
          state_next_s      = wb_cyc_i ? S_ERR : S_IDLE;
        end else if (sd_byte_valid_i) begin
          last_byte_next_s = sd_byte_i;
          dat_next_s       = WB_DATA'(sd_byte_i);
          state_next_s     = wb_cyc_i ? S_ACK : S_IDLE;
          if (byte_idx_r == 9'd511) begin
            byte_idx_next_s   = 9'd0;
            block_open_next_s = 1'b0;
            cur_block_next_s  = cur_block_r + 32'd1;
          end else begin
            byte_idx_next_s = byte_idx_r + 9'd1;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_sticky_next_s = 1'b1;
          block_open_next_s = 1'b0;
          state_next_s      = wb_cyc_i ? S_ERR : S_IDLE;
        end else begin
          tmo_cnt_next_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      S_ACK:          state_next_s = S_WAIT_STB_LOW;
      S_ERR:          state_next_s = S_WAIT_STB_LOW;
      S_WAIT_STB_LOW: state_next_s = wb_stb_i ? S_WAIT_STB_LOW : S_IDLE;
      default:        state_next_s = S_IDLE;
    endcase
  end

  // State, register file and registered bus/SD outputs
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r      <= S_IDLE;
      cur_block_r  <= 32'd0;
      byte_idx_r   <= 9'd0;
      block_open_r <= 1'b0;
      last_byte_r  <= 8'd0;
      sclk_r       <= SCLK_RESET;
      tmo_sticky_r <= 1'b0;
      err_sticky_r <= 1'b0;
      tmo_cnt_r    <= {TMO_W{1'b0}};
      sd_block_r   <= 32'd0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      wb_dat_o     <= {WB_DATA{1'b0}};
      sd_start_o   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cur_block_r  <= cur_block_next_s;
      byte_idx_r   <= byte_idx_next_s;
      block_open_r <= block_open_next_s;
      last_byte_r  <= last_byte_next_s;
      sclk_r       <= sclk_next_s;
      tmo_sticky_r <= tmo_sticky_next_s;
      err_sticky_r <= err_sticky_next_s;
      tmo_cnt_r    <= tmo_cnt_next_s;
      sd_block_r   <= sd_block_next_s;
      wb_ack_o     <= (state_next_s == S_ACK);
      wb_err_o     <= (state_next_s == S_ERR);
      wb_dat_o     <= (state_next_s == S_ACK) ? dat_next_s : {WB_DATA{1'b0}};
      sd_start_o   <= (state_next_s == S_OPEN_BLOCK);
    end
  end

endmodule
